// File: rtl/stack_ctrl.sv
// Stack engine: sequences push/pop through the data-memory bus and strobes the SP register.
// Optional macro STACK_GUARD_EN enables overflow/underflow checks with a stack_err pulse.
module stack_ctrl #(
    parameter logic [15:0] STACK_LIMIT = 16'hFF00,
    parameter int unsigned DATA_W      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push_req,
    input  logic              pop_req,
    input  logic [DATA_W-1:0] push_data,
    output logic              busy,
    output logic              pop_valid,
    output logic [DATA_W-1:0] pop_data,
    input  logic [15:0]       sp_in,
    output logic              sp_pop,
    output logic              sp_push,
    output logic [15:0]       sp_new_val,
    output logic              mem_req,
    output logic              mem_we,
    output logic [15:0]       mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              stack_err
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MEM  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

`ifdef STACK_GUARD_EN
    localparam logic GUARD_EN = 1'b1;
`else
    localparam logic GUARD_EN = 1'b0;
`endif

    logic [1:0]        r_state;
    logic              r_op_pop;
    logic              r_mem_req;
    logic              r_mem_we;
    logic [15:0]       r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [DATA_W-1:0] r_pop_data;
    logic              r_stack_err;

    logic              w_pop_err;
    logic              w_push_err;
    logic              w_done;
    logic [15:0]       w_sp_inc;
    logic [15:0]       w_sp_dec;

    assign w_sp_inc   = sp_in + 16'd1;
    assign w_sp_dec   = sp_in - 16'd1;
    assign w_pop_err  = GUARD_EN && (sp_in == 16'hFFFF);
    assign w_push_err = GUARD_EN && (sp_in < STACK_LIMIT);
    assign w_done     = (r_state == ST_DONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_op_pop    <= 1'b0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_pop_data  <= '0;
            r_stack_err <= 1'b0;
        end else begin
            r_stack_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    // Pop has priority over a simultaneous push, matching the SP register
                    if (pop_req) begin
                        if (w_pop_err) begin
                            r_stack_err <= 1'b1;
                        end else begin
                            r_op_pop   <= 1'b1;
                            r_state    <= ST_MEM;
                            r_mem_req  <= 1'b1;
                            r_mem_we   <= 1'b0;
                            r_mem_addr <= w_sp_inc;
                        end
                    end else if (push_req) begin
                        if (w_push_err) begin
                            r_stack_err <= 1'b1;
                        end else begin
                            r_op_pop    <= 1'b0;
                            r_state     <= ST_MEM;
                            r_mem_req   <= 1'b1;
                            r_mem_we    <= 1'b1;
                            r_mem_addr  <= sp_in;
                            r_mem_wdata <= push_data;
                        end
                    end
                end
                ST_MEM: begin
                    if (mem_ack) begin
                        r_mem_req <= 1'b0;
                        r_state   <= ST_DONE;
                        if (r_op_pop) begin
                            r_pop_data <= mem_rdata;
                        end
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_mem_req <= 1'b0;
                end
            endcase
        end
    end

    assign busy       = (r_state == ST_MEM) || w_done;
    assign sp_pop     = w_done && r_op_pop;
    assign sp_push    = w_done && !r_op_pop;
    assign pop_valid  = w_done && r_op_pop;
    assign sp_new_val = w_done ? (r_op_pop ? w_sp_inc : w_sp_dec) : '0;
    assign mem_req    = r_mem_req;
    assign mem_we     = r_mem_we;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;
    assign pop_data   = r_pop_data;
    assign stack_err  = r_stack_err && GUARD_EN;

endmodule

// File: tb/tb_stack_ctrl.sv
// Bench for stack_ctrl: transaction-level model checked every cycle plus directed literal checks.
// Honours STACK_GUARD_EN the same way as the design.
module tb_stack_ctrl;

`ifdef STACK_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif
    localparam logic [15:0] LIMIT = 16'hFF00;

    logic        clk = 1'b0;
    logic        reset;
    logic        push_req, pop_req;
    logic [15:0] push_data;
    logic        busy, pop_valid;
    logic [15:0] pop_data;
    logic [15:0] sp_in;
    logic        sp_pop, sp_push;
    logic [15:0] sp_new_val;
    logic        mem_req, mem_we;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_ack;
    logic        stack_err;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    stack_ctrl #(.STACK_LIMIT(16'hFF00), .DATA_W(16)) dut (
        .clk(clk), .reset(reset), .push_req(push_req), .pop_req(pop_req),
        .push_data(push_data), .busy(busy), .pop_valid(pop_valid), .pop_data(pop_data),
        .sp_in(sp_in), .sp_pop(sp_pop), .sp_push(sp_push), .sp_new_val(sp_new_val),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .stack_err(stack_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Model: one outstanding transaction, a completion cycle, and the last bus values issued
    typedef struct {
        bit          is_pop;
        bit          we;
        logic [15:0] addr;
        logic [15:0] wdata;
    } txn_t;

    txn_t        m_txn;
    bit          m_waiting_mem;
    bit          m_completing;
    bit          m_err;
    logic [15:0] m_pop_data;

    initial begin
        logic [15:0] e_nv;
        logic [15:0] nxt;
        bit          bad;
        m_txn = '{is_pop: 1'b0, we: 1'b0, addr: 16'h0, wdata: 16'h0};
        m_waiting_mem = 0; m_completing = 0; m_err = 0; m_pop_data = '0;
        forever begin
            @(posedge clk);
            if (reset) begin
                m_txn = '{is_pop: 1'b0, we: 1'b0, addr: 16'h0, wdata: 16'h0};
                m_waiting_mem = 0; m_completing = 0; m_err = 0; m_pop_data = '0;
            end else begin
                m_err = 0;
                if (m_completing) begin
                    m_completing = 0;
                end else if (m_waiting_mem) begin
                    if (mem_ack) begin
                        m_waiting_mem = 0;
                        m_completing  = 1;
                        if (m_txn.is_pop) m_pop_data = mem_rdata;
                    end
                end else if (pop_req || push_req) begin
                    bad = GUARD && (pop_req ? (sp_in == 16'hFFFF) : (sp_in < LIMIT));
                    if (bad) begin
                        m_err = 1;
                    end else begin
                        nxt = sp_in + 16'd1;
                        m_txn.is_pop = pop_req;
                        m_txn.we     = !pop_req;
                        m_txn.addr   = pop_req ? nxt : sp_in;
                        if (!pop_req) m_txn.wdata = push_data;
                        m_waiting_mem = 1;
                    end
                end
            end
            #1;
            e_nv = '0;
            if (m_completing) e_nv = m_txn.is_pop ? sp_in + 16'd1 : sp_in - 16'd1;
            chk("m_busy",      busy,       32'(m_waiting_mem || m_completing));
            chk("m_mem_req",   mem_req,    32'(m_waiting_mem));
            chk("m_mem_we",    mem_we,     32'(m_txn.we));
            chk("m_mem_addr",  mem_addr,   32'(m_txn.addr));
            chk("m_mem_wdata", mem_wdata,  32'(m_txn.wdata));
            chk("m_pop_valid", pop_valid,  32'(m_completing && m_txn.is_pop));
            chk("m_sp_pop",    sp_pop,     32'(m_completing && m_txn.is_pop));
            chk("m_sp_push",   sp_push,    32'(m_completing && !m_txn.is_pop));
            chk("m_sp_new",    sp_new_val, 32'(e_nv));
            chk("m_pop_data",  pop_data,   32'(m_pop_data));
            chk("m_stack_err", stack_err,  32'(m_err));
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    // Back-to-back operations: {is_pop, sp, data, ack delay}
    logic        t_pop   [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [15:0] t_sp    [4] = '{16'hFF80, 16'hFF7F, 16'hFFF0, 16'hFFEF};
    logic [15:0] t_data  [4] = '{16'hC0DE, 16'h3C3C, 16'h0001, 16'hFFFE};
    int unsigned t_delay [4] = '{0, 2, 1, 0};

    initial begin
        reset = 1; push_req = 0; pop_req = 0; push_data = '0;
        sp_in = 16'hFFFF; mem_rdata = '0; mem_ack = 0;
        step(); step();
        chk("rst_busy", busy, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_pop_data", pop_data, 0);
        chk("rst_sp_new_val", sp_new_val, 0);
        chk("rst_stack_err", stack_err, 0);

        // Push 1234 at FFFF with same-cycle ack
        reset = 0; push_req = 1; push_data = 16'h1234;
        step();
        push_req = 0;
        chk("push_we", mem_we, 1);
        chk("push_addr", mem_addr, 16'hFFFF);
        chk("push_wdata", mem_wdata, 16'h1234);
        chk("push_busy1", busy, 1);
        mem_ack = 1;
        step();
        mem_ack = 0;
        chk("push_sp_push", sp_push, 1);
        chk("push_new_val", sp_new_val, 16'hFFFE);
        chk("push_busy2", busy, 1);
        step();
        chk("push_busy_end", busy, 0);

        // Pop at FFFE, ack after 3 wait cycles
        sp_in = 16'hFFFE; pop_req = 1;
        step();
        pop_req = 0;
        for (int i = 0; i < 4; i++) begin
            chk("pop_req_held", mem_req, 1);
            chk("pop_addr", mem_addr, 16'hFFFF);
            if (i == 3) begin
                mem_ack = 1; mem_rdata = 16'h1234;
            end
            step();
        end
        mem_ack = 0; mem_rdata = '0;
        chk("pop_valid", pop_valid, 1);
        chk("pop_data", pop_data, 16'h1234);
        chk("pop_sp_pop", sp_pop, 1);
        chk("pop_new_val", sp_new_val, 16'hFFFF);
        step();
        chk("pop_valid_end", pop_valid, 0);
        chk("pop_data_held", pop_data, 16'h1234);

        // Simultaneous push and pop: pop wins
        sp_in = 16'hFFFD; push_req = 1; pop_req = 1; push_data = 16'hAAAA;
        step();
        push_req = 0; pop_req = 0;
        chk("both_we", mem_we, 0);
        chk("both_addr", mem_addr, 16'hFFFE);
        mem_ack = 1; mem_rdata = 16'h5555;
        step();
        mem_ack = 0;
        chk("both_sp_pop", sp_pop, 1);
        chk("both_sp_push", sp_push, 0);
        chk("both_new_val", sp_new_val, 16'hFFFE);
        step();
        sp_in = 16'hFFFE;

        // Stray ack in IDLE
        mem_ack = 1;
        step();
        mem_ack = 0;
        chk("idle_ack_busy", busy, 0);

        // Reset during MEM
        push_req = 1; push_data = 16'hBEEF;
        step();
        push_req = 0;
        chk("mid_req", mem_req, 1);
        reset = 1;
        step();
        chk("mid_rst_req", mem_req, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_push", sp_push, 0);
        chk("mid_rst_valid", pop_valid, 0);
        chk("mid_rst_data", pop_data, 0);
        reset = 0;
        step();

`ifdef STACK_GUARD_EN
        sp_in = 16'hFFFF; pop_req = 1;
        step();
        pop_req = 0;
        chk("uflow_err", stack_err, 1);
        chk("uflow_req", mem_req, 0);
        chk("uflow_busy", busy, 0);
        step();
        chk("uflow_err_end", stack_err, 0);
        sp_in = 16'hFEFF; push_req = 1; push_data = 16'h0F0F;
        step();
        push_req = 0;
        chk("oflow_err", stack_err, 1);
        chk("oflow_req", mem_req, 0);
        step();
        chk("oflow_err_end", stack_err, 0);
        sp_in = 16'hFF00; push_req = 1;
        step();
        push_req = 0;
        chk("limit_req", mem_req, 1);
        chk("limit_addr", mem_addr, 16'hFF00);
        mem_ack = 1;
        step();
        mem_ack = 0;
        chk("limit_new_val", sp_new_val, 16'hFEFF);
        step();
`else
        sp_in = 16'hFFFF; pop_req = 1;
        step();
        pop_req = 0;
        chk("wrap_addr", mem_addr, 16'h0000);
        chk("wrap_err", stack_err, 0);
        mem_ack = 1; mem_rdata = 16'h7777;
        step();
        mem_ack = 0;
        chk("wrap_new_val", sp_new_val, 16'h0000);
        chk("wrap_sp_pop", sp_pop, 1);
        step();
        sp_in = 16'hFEFF; push_req = 1; push_data = 16'h0F0F;
        step();
        push_req = 0;
        chk("below_addr", mem_addr, 16'hFEFF);
        chk("below_we", mem_we, 1);
        mem_ack = 1;
        step();
        mem_ack = 0;
        chk("below_new_val", sp_new_val, 16'hFEFE);
        step();
`endif

        for (int k = 0; k < 4; k++) begin
            sp_in = t_sp[k]; push_data = t_data[k];
            pop_req = t_pop[k]; push_req = !t_pop[k];
            step();
            pop_req = 0; push_req = 0;
            for (int unsigned d = 0; d < t_delay[k]; d++) step();
            mem_ack = 1; mem_rdata = ~t_data[k];
            step();
            mem_ack = 0;
            step();
        end
        step(); step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
